// File: rtl/debounce_bank.sv
`default_nettype none
// ============================================================================
// debounce_bank : per-channel 2-FF sync, stability debounce, edge/long-press pulses
// Revision      : 1.0
// ============================================================================
module debounce_bank #(
    parameter int CHANNELS      = 4,
    parameter int STABLE_CYCLES = 1024,
    parameter int HOLD_CYCLES   = 500000,
    parameter int REPEAT_CYCLES = 0,
    parameter bit RESET_LEVEL   = 1'b0
) (
    input  logic                clk,
    input  logic                n_reset,
    input  logic [CHANNELS-1:0] button_in,
    output logic [CHANNELS-1:0] db_out,
    output logic [CHANNELS-1:0] rise_pulse,
    output logic [CHANNELS-1:0] fall_pulse,
    output logic [CHANNELS-1:0] long_press
);

    localparam int CNT_W    = $clog2(STABLE_CYCLES);
    localparam int HOLD_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int HCNT_W   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

    localparam logic [CNT_W-1:0]  STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [HCNT_W-1:0] HOLD_LAST   = HCNT_W'(HOLD_CYCLES - 1);
    localparam logic [HCNT_W-1:0] REPEAT_LAST = HCNT_W'(REPEAT_CYCLES - 1);

    genvar i;
    for (i = 0; i < CHANNELS; i++) begin : g_ch
        logic              sync1_q, s_q;
        logic              db_q, db_d;
        logic              rise_q, rise_d;
        logic              fall_q, fall_d;
        logic              long_q, long_d;
        logic              rep_q, rep_d;
        logic [CNT_W-1:0]  cnt_q, cnt_d;
        logic [HCNT_W-1:0] hcnt_q, hcnt_d;

        always_comb begin
            db_d   = db_q;
            cnt_d  = cnt_q;
            rise_d = 1'b0;
            fall_d = 1'b0;
            if (s_q == db_q) begin
                cnt_d = '0;
            end else if (cnt_q == STABLE_LAST) begin
                db_d   = s_q;
                cnt_d  = '0;
                rise_d = s_q;
                fall_d = ~s_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        // A rise implies db_q==0, so it is covered by the first clear term;
        // clearing on fall keeps long_press from ever landing on a release.
        always_comb begin
            hcnt_d = hcnt_q;
            rep_d  = rep_q;
            long_d = 1'b0;
            if (!db_q || fall_d) begin
                hcnt_d = '0;
                rep_d  = 1'b0;
            end else if (!rep_q) begin
                if (hcnt_q == HOLD_LAST) begin
                    long_d = 1'b1;
                    hcnt_d = '0;
                    rep_d  = 1'b1;
                end else begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end else if (REPEAT_CYCLES != 0) begin
                if (hcnt_q == REPEAT_LAST) begin
                    long_d = 1'b1;
                    hcnt_d = '0;
                end else begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge clk or negedge n_reset) begin
            if (!n_reset) begin
                sync1_q <= RESET_LEVEL;
                s_q     <= RESET_LEVEL;
                db_q    <= RESET_LEVEL;
                cnt_q   <= '0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
                long_q  <= 1'b0;
                rep_q   <= 1'b0;
                hcnt_q  <= '0;
            end else begin
                sync1_q <= button_in[i];
                s_q     <= sync1_q;
                db_q    <= db_d;
                cnt_q   <= cnt_d;
                rise_q  <= rise_d;
                fall_q  <= fall_d;
                long_q  <= long_d;
                rep_q   <= rep_d;
                hcnt_q  <= hcnt_d;
            end
        end

        assign db_out[i]     = db_q;
        assign rise_pulse[i] = rise_q;
        assign fall_pulse[i] = fall_q;
        assign long_press[i] = long_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_debounce_bank.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_debounce_bank : scenario tasks plus random run against a timing-rule model
// Revision         : 1.0
// ============================================================================
module tb_debounce_bank;

    localparam int STB  = 8;
    localparam int HOLD = 20;
    localparam int REP  = 5;
    localparam int MAXT = 4096;

    logic       clk;
    logic       n_reset;
    logic [1:0] button_in;
    logic [1:0] db_out, rise_pulse, fall_pulse, long_press;
    logic [1:0] db_nr, rise_nr, fall_nr, long_nr;

    debounce_bank #(
        .CHANNELS(2), .STABLE_CYCLES(STB), .HOLD_CYCLES(HOLD),
        .REPEAT_CYCLES(REP), .RESET_LEVEL(1'b0)
    ) dut (
        .clk(clk), .n_reset(n_reset), .button_in(button_in),
        .db_out(db_out), .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse), .long_press(long_press)
    );

    debounce_bank #(
        .CHANNELS(2), .STABLE_CYCLES(STB), .HOLD_CYCLES(HOLD),
        .REPEAT_CYCLES(0), .RESET_LEVEL(1'b0)
    ) dut_nr (
        .clk(clk), .n_reset(n_reset), .button_in(button_in),
        .db_out(db_nr), .rise_pulse(rise_nr),
        .fall_pulse(fall_nr), .long_press(long_nr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: s history by edge index; db flips when the last STB samples all differ.
    int         t;
    logic [1:0] s_at [0:MAXT-1];
    logic [1:0] m_sync1, m_db, e_rise, e_fall, e_long, e_long0;
    int         rise_t [2];

    logic [15:0] obs, exp_v;
    assign obs   = {db_out, rise_pulse, fall_pulse, long_press, db_nr, rise_nr, fall_nr, long_nr};
    assign exp_v = {m_db, e_rise, e_fall, e_long, m_db, e_rise, e_fall, e_long0};

    task automatic model_reset();
        t        = 0;
        m_sync1  = '0;
        m_db     = '0;
        e_rise   = '0;
        e_fall   = '0;
        e_long   = '0;
        e_long0  = '0;
        s_at[0]  = '0;
        rise_t[0] = 0;
        rise_t[1] = 0;
    endtask

    task automatic model_edge(input logic [1:0] b);
        logic flip;
        int   el;
        t++;
        if (t >= MAXT) begin
            $display("FAIL model_range: edge index %0d, required below %0d", t, MAXT);
            $fatal(1);
        end
        for (int i = 0; i < 2; i++) begin
            flip = (t >= STB);
            for (int k = t - STB; k < t; k++)
                if (k >= 0 && s_at[k][i] == m_db[i]) flip = 1'b0;
            e_rise[i]  = flip && !m_db[i];
            e_fall[i]  = flip && m_db[i];
            e_long[i]  = 1'b0;
            e_long0[i] = 1'b0;
            if (m_db[i] && !flip) begin
                el         = t - rise_t[i];
                e_long[i]  = (el == HOLD) || (el > HOLD && ((el - HOLD) % REP) == 0);
                e_long0[i] = (el == HOLD);
            end
            if (flip) m_db[i] = ~m_db[i];
            if (e_rise[i]) rise_t[i] = t;
        end
        s_at[t] = m_sync1;
        m_sync1 = b;
    endtask

    task automatic tick(input logic [1:0] b);
        button_in = b;
        @(posedge clk);
        model_edge(b);
        #1;
    endtask

    task automatic assert_reset();
        #2 n_reset = 1'b0;
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        n_reset = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        n_reset   = 1'b0;
        button_in = 2'b00;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (obs !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_values: observed %h required 0000", obs);
        end
        release_reset();
        for (int j = 0; j < 4; j++) begin
            tick(2'b00);
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL reset_idle: observed %h required %h", obs, exp_v);
            end
        end
    endtask

    task automatic test_clean_press();
        int rise_at = -1;
        for (int j = 0; j < 30; j++) begin
            tick(j < 16 ? 2'b01 : 2'b00);
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL clean_press: cycle %0d observed %h required %h", j, obs, exp_v);
            end
            if (rise_pulse[0] && rise_at < 0) rise_at = j;
        end
        n_checks++;
        if (rise_at != 9) begin
            n_fail++;
            $display("FAIL clean_press_latency: rise at edge %0d, required 9", rise_at);
        end
    endtask

    task automatic test_bounce();
        int rise_at = -1;
        int n_edges = 0;
        logic [1:0] b;
        for (int j = 0; j < 46; j++) begin
            if (j < 12)      b = ((j / 3) % 2 == 0) ? 2'b01 : 2'b00;
            else if (j < 32) b = 2'b01;
            else             b = 2'b00;
            tick(b);
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL bounce: cycle %0d observed %h required %h", j, obs, exp_v);
            end
            if (j < 32 && (rise_pulse[0] || fall_pulse[0])) n_edges++;
            if (rise_pulse[0] && rise_at < 0) rise_at = j;
        end
        n_checks++;
        if (rise_at != 21 || n_edges != 1) begin
            n_fail++;
            $display("FAIL bounce_rise: rise at %0d with %0d edges, required 21 with 1", rise_at, n_edges);
        end
    endtask

    task automatic test_long_press();
        int n_long = 0, n_long_nr = 0, n_fall = 0, first_nr = -1, fall_at = -1, clash = 0;
        for (int j = 0; j < 92; j++) begin
            tick(j < 70 ? 2'b01 : 2'b00);
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL long_press: cycle %0d observed %h required %h", j, obs, exp_v);
            end
            if (long_press[0]) n_long++;
            if (long_nr[0]) begin
                n_long_nr++;
                if (first_nr < 0) first_nr = j;
            end
            if (fall_pulse[0]) begin
                n_fall++;
                fall_at = j;
                if (long_press[0]) clash++;
            end
        end
        n_checks++;
        if (n_long != 10 || clash != 0) begin
            n_fail++;
            $display("FAIL long_repeat_count: %0d pulses %0d clashes, required 10 and 0", n_long, clash);
        end
        n_checks++;
        if (n_long_nr != 1 || first_nr != 29) begin
            n_fail++;
            $display("FAIL long_norepeat: %0d pulses first at %0d, required 1 at 29", n_long_nr, first_nr);
        end
        n_checks++;
        if (n_fall != 1 || fall_at != 79) begin
            n_fail++;
            $display("FAIL long_release: %0d falls at %0d, required 1 at 79", n_fall, fall_at);
        end
    endtask

    task automatic test_simultaneous();
        int n_both = 0, n_fall1 = 0;
        logic [1:0] b;
        for (int j = 0; j < 40; j++) begin
            b = (j < 12) ? 2'b11 : (j < 26) ? 2'b01 : 2'b00;
            tick(b);
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL simultaneous: cycle %0d observed %h required %h", j, obs, exp_v);
            end
            if (rise_pulse == 2'b11) n_both++;
            if (j < 26 && fall_pulse == 2'b10) n_fall1++;
        end
        n_checks++;
        if (n_both != 1 || n_fall1 != 1) begin
            n_fail++;
            $display("FAIL simultaneous_pulses: rise11=%0d fall10=%0d, required 1 and 1", n_both, n_fall1);
        end
    endtask

    task automatic test_async_reset();
        int rise_at = -1;
        for (int j = 0; j < 7; j++) tick(2'b01);
        assert_reset();
        n_checks++;
        if (obs !== 16'h0000) begin
            n_fail++;
            $display("FAIL async_reset_count: observed %h required 0000", obs);
        end
        release_reset();
        for (int j = 0; j < 32; j++) begin
            tick(2'b01);
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL async_reset_rearm: cycle %0d observed %h required %h", j, obs, exp_v);
            end
            if (rise_pulse[0] && rise_at < 0) rise_at = j;
        end
        n_checks++;
        if (rise_at != 9) begin
            n_fail++;
            $display("FAIL async_reset_latency: rise at %0d, required 9", rise_at);
        end
        assert_reset();
        n_checks++;
        if (obs !== 16'h0000) begin
            n_fail++;
            $display("FAIL async_reset_hold: observed %h required 0000", obs);
        end
        release_reset();
        for (int j = 0; j < 6; j++) begin
            tick(2'b00);
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL async_reset_idle: cycle %0d observed %h required %h", j, obs, exp_v);
            end
        end
    endtask

    task automatic test_random();
        int run [2];
        logic [1:0] b;
        b      = button_in;
        run[0] = 0;
        run[1] = 0;
        for (int c = 0; c < 2000; c++) begin
            for (int ch = 0; ch < 2; ch++) begin
                if (run[ch] == 0) begin
                    b[ch]   = ~b[ch];
                    run[ch] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(25, 60))
                                                          : int'($urandom_range(1, 12));
                end
                run[ch]--;
            end
            tick(b);
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL random: cycle %0d in %b observed %h required %h", c, b, obs, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_long_press();
        test_simultaneous();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
